// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one ble_uart_tx among NUM_REQ valid/ready byte producers.
// Define UART_ARB_TAG_EN to send a tag frame (8'hA0 | winner index) ahead of each data byte.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [8*NUM_REQ-1:0]       req_data_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    output logic [7:0]                 tx_data_out,
    output logic                       tx_enable_out,
    input  logic                       tx_busy_in,
    input  logic                       tx_done_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_out,
    output logic                       active_out,
    output logic                       timeout_err_out
);
    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [2:0] {IDLE, TAG_LAUNCH, TAG_WAIT, LAUNCH, WAIT_DONE} state_t;
    logic [7:0] data_hold;
`else
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
`endif

    state_t        state;
    logic [IW-1:0] rr;
    logic [CW-1:0] cnt;

    logic          found_hi, found_lo, found;
    logic [IW-1:0] idx_hi, idx_lo, winner;
    logic [7:0]    byte_hi, byte_lo, win_byte;

    // Rotation done as two fixed-index scans: first valid above rr, else first valid at/below rr.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        byte_hi  = '0;
        byte_lo  = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (req_valid_in[j] && (IW'(j) > rr) && !found_hi) begin
                found_hi = 1'b1;
                idx_hi   = IW'(j);
                byte_hi  = req_data_in[8*j +: 8];
            end
            if (req_valid_in[j] && (IW'(j) <= rr) && !found_lo) begin
                found_lo = 1'b1;
                idx_lo   = IW'(j);
                byte_lo  = req_data_in[8*j +: 8];
            end
        end
        found    = found_hi | found_lo;
        winner   = found_hi ? idx_hi : idx_lo;
        win_byte = found_hi ? byte_hi : byte_lo;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            rr              <= IW'(NUM_REQ - 1);
            cnt             <= '0;
            req_ready_out   <= '0;
            tx_data_out     <= '0;
            tx_enable_out   <= 1'b0;
            grant_idx_out   <= '0;
            active_out      <= 1'b0;
            timeout_err_out <= 1'b0;
`ifdef UART_ARB_TAG_EN
            data_hold       <= '0;
`endif
        end else begin
            req_ready_out <= '0;
            tx_enable_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        req_ready_out <= NUM_REQ'(1) << winner;
                        grant_idx_out <= winner;
                        rr            <= winner;
                        active_out    <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        data_hold     <= win_byte;
                        tx_data_out   <= {4'hA, 4'(winner)};
                        state         <= TAG_LAUNCH;
`else
                        tx_data_out   <= win_byte;
                        state         <= LAUNCH;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                TAG_LAUNCH: begin
                    if (!tx_busy_in) begin
                        tx_enable_out <= 1'b1;
                        cnt           <= '0;
                        state         <= TAG_WAIT;
                    end
                end
                TAG_WAIT: begin
                    if (tx_done_in) begin
                        tx_data_out <= data_hold;
                        state       <= LAUNCH;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err_out <= 1'b1;
                        active_out      <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                LAUNCH: begin
                    if (!tx_busy_in) begin
                        tx_enable_out <= 1'b1;
                        cnt           <= '0;
                        state         <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done_in) begin
                        active_out <= 1'b0;
                        state      <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err_out <= 1'b1;
                        active_out      <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural ble_uart_tx (busy/done timing only).
// Also builds with UART_ARB_TAG_EN defined; expected frames then include the tag byte.
module tb_uart_tx_arbiter;
    localparam int unsigned NR    = 4;
    localparam int unsigned TO    = 100;
    localparam int unsigned FRAME = 20;
`ifdef UART_ARB_TAG_EN
    localparam int unsigned NF = 2;
`else
    localparam int unsigned NF = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data;
    logic            tx_enable;
    logic            tx_busy;
    logic            tx_done = 1'b0;
    logic [1:0]      grant_idx;
    logic            active;
    logic            timeout_err;

    bit   model_busy = 1'b0;
    bit   force_busy = 1'b0;
    bit   suppress_done = 1'b0;
    int   busy_cnt = 0;
    int   rem[NR] = '{default: 0};
    int   n_ready = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [11:0] sb[$];

    assign tx_busy = model_busy | force_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .req_valid_in    (req_valid),
        .req_data_in     (req_data),
        .req_ready_out   (req_ready),
        .tx_data_out     (tx_data),
        .tx_enable_out   (tx_enable),
        .tx_busy_in      (tx_busy),
        .tx_done_in      (tx_done),
        .grant_idx_out   (grant_idx),
        .active_out      (active),
        .timeout_err_out (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_grant(input int idx, input logic [7:0] b);
`ifdef UART_ARB_TAG_EN
        sb.push_back({4'(idx), 4'hA, 4'(idx)});
`endif
        sb.push_back({4'(idx), b});
    endtask

    // Only the first frame of a grant goes out before a timeout.
    task automatic expect_dropped(input int idx, input logic [7:0] b);
`ifdef UART_ARB_TAG_EN
        sb.push_back({4'(idx), 4'hA, 4'(idx)});
`else
        sb.push_back({4'(idx), b});
`endif
    endtask

    function automatic bit reqs_pending();
        bit p = 1'b0;
        for (int i = 0; i < NR; i++) if (rem[i] > 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_all(input string tag);
        int n = 0;
        while ((reqs_pending() || active || sb.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 3000), 1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready == '0 && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 50), 1);
    endtask

    task automatic wait_enable(input string tag);
        int n = 0;
        while (!tx_enable && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 50), 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!tx_done && n < 200);
        check(tag, 32'(tx_done), 1);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_ready"}, 32'(req_ready), 0);
        check({pfx, "_data"}, 32'(tx_data), 0);
        check({pfx, "_enable"}, 32'(tx_enable), 0);
        check({pfx, "_grant"}, 32'(grant_idx), 0);
        check({pfx, "_active"}, 32'(active), 0);
        check({pfx, "_err"}, 32'(timeout_err), 0);
    endtask

    // Transmitter model, requester handshakes and frame scoreboard, all updated on the falling edge.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_busy = 1'b0;
                busy_cnt   = 0;
                tx_done    = 1'b0;
            end else begin
                tx_done = 1'b0;
                if (tx_enable) begin
                    check("enable_while_busy", 32'(tx_busy), 0);
                    if (sb.size() == 0) begin
                        check("unexpected_frame", {20'd0, 2'b00, grant_idx, tx_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("frame_idx_data", {20'd0, 2'b00, grant_idx, tx_data}, {20'd0, e});
                    end
                    model_busy = 1'b1;
                    busy_cnt   = FRAME;
                end else if (model_busy) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        model_busy = 1'b0;
                        tx_done    = !suppress_done;
                    end
                end
            end
            if (req_ready != '0) check("ready_onehot", 32'($onehot(req_ready)), 1);
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    n_ready++;
                    check("ready_without_valid", 32'(rem[i] > 0), 1);
                    if (rem[i] > 0) rem[i]--;
                end
                req_valid[i] = (rem[i] > 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int n0;
        int n_en;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("rst");
        rst_n = 1'b1;

        // Single requester: ready pulse, enable one cycle later, active falls after done
        req_data[7:0] = 8'h93;
        expect_grant(0, 8'h93);
        rem[0] = 1;
        wait_ready("s_ready_seen");
        check("s_ready_vec", 32'(req_ready), 32'b0001);
        check("s_active_up", 32'(active), 1);
        check("s_enable_early", 32'(tx_enable), 0);
        tick();
        check("s_ready_one_cycle", 32'(req_ready), 0);
        check("s_enable_next", 32'(tx_enable), 1);
        for (int f = 0; f < NF; f++) wait_done("s_done_seen");
        check("s_active_at_done", 32'(active), 1);
        tick();
        check("s_active_fall", 32'(active), 0);
        wait_all("s_drain");

        // Round robin from reset pointer: 0,1,2,3,0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        expect_grant(0, 8'h10);
        expect_grant(1, 8'h11);
        expect_grant(2, 8'h12);
        expect_grant(3, 8'h13);
        expect_grant(0, 8'h10);
        n0 = n_ready;
        rem = '{2, 1, 1, 1};
        wait_all("rr_drain");
        check("rr_ready_count", 32'(n_ready - n0), 5);

        // Priority resume: after grant to 2, requester 3 beats requester 1
        req_data[23:16] = 8'h22;
        expect_grant(2, 8'h22);
        rem[2] = 1;
        wait_all("pr_first");
        req_data[15:8]  = 8'h11;
        req_data[31:24] = 8'h33;
        expect_grant(3, 8'h33);
        expect_grant(1, 8'h11);
        rem[1] = 1;
        rem[3] = 1;
        wait_all("pr_pair");

        // Busy gating: no enable while busy, enable on first free cycle
        force_busy = 1'b1;
        req_data[7:0] = 8'h5A;
        expect_grant(0, 8'h5A);
        rem[0] = 1;
        wait_ready("bg_ready_seen");
        n_en = 0;
        repeat (50) begin
            tick();
            if (tx_enable) n_en++;
        end
        check("bg_no_enable", 32'(n_en), 0);
        check("bg_active_held", 32'(active), 1);
        force_busy = 1'b0;
        tick();
        check("bg_enable_first_free", 32'(tx_enable), 1);
        wait_all("bg_drain");

        // Timeout: error rises exactly TO cycles after the enable pulse, then sticky
        suppress_done = 1'b1;
        req_data[15:8] = 8'h77;
        expect_dropped(1, 8'h77);
        rem[1] = 1;
        wait_enable("to_enable_seen");
        n = 0;
        while (!timeout_err && n < 300) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), TO);
        check("to_active_clear", 32'(active), 0);
        suppress_done = 1'b0;
        req_data[23:16] = 8'h44;
        expect_grant(2, 8'h44);
        rem[2] = 1;
        wait_all("to_next_served");
        check("to_sticky", 32'(timeout_err), 1);
        check("sb_empty", 32'(sb.size()), 0);

        // Reset mid-transfer clears everything on the next cycle
        req_data[31:24] = 8'h66;
        expect_grant(3, 8'h66);
        rem[3] = 1;
        wait_enable("rm_enable_seen");
        repeat (3) tick();
        check("rm_in_flight", 32'(active), 1);
        rst_n = 1'b0;
        tick();
        check_all_zero("rm");
        rst_n = 1'b1;
        sb.delete();
        rem = '{default: 0};

        // Recovery after reset: requester 0 first again
        req_data[7:0] = 8'hE1;
        expect_grant(0, 8'hE1);
        rem[0] = 1;
        wait_all("post_reset_served");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
